ram_dma: RTL

Block-transfer engine that acts as the initiator on the general-purpose RAM port (Cs/Wen/Oen/Address/data). It copies a block of bytes from one RAM region to another, or fills a region with a constant, without CPU involvement. It sits beside the CPU data path and is arbitrated onto the RAM through a request/grant pair. Transfer parameters are written by the CPU, which then pulses `Start`.

---
 rtl/ram_dma.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ram_dma.sv
// ram_dma: block-transfer engine mastering the general-purpose RAM port.
// Copies a block of bytes between two RAM regions (ascending addresses) or,
// when built with RAM_DMA_FILL_EN defined, fills a region with a constant.
// Without RAM_DMA_FILL_EN, Mode and FillData are ignored and every transfer
// is a copy.
module ram_dma #(
  parameter int RAM_DEPTH = 256
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Start,
  input  logic       Mode,
  input  logic [7:0] SrcAddr,
  input  logic [7:0] DstAddr,
  input  logic [7:0] Length,
  input  logic [7:0] FillData,
  input  logic       Abort,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Remaining,
  output logic       BusReq,
  input  logic       BusGnt,
  output logic       Cs,
  output logic       Wen,
  output logic       Oen,
  output logic [7:0] Address,
  output logic [7:0] WrData,
  input  logic [7:0] RdData
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    READ  = 3'd2,
    CAPT  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] dst_q, dst_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] data_q, data_d;
  logic       is_fill;
  logic       acc_ok;

  // Address increment that wraps at the top of the RAM.
  function automatic logic [7:0] wrap_inc(input logic [7:0] a);
    if ({24'd0, a} >= 32'(RAM_DEPTH - 1)) begin
      return 8'd0;
    end
    return a + 8'd1;
  endfunction

`ifdef RAM_DMA_FILL_EN
  logic       mode_q, mode_d;
  logic [7:0] fill_q, fill_d;

  assign is_fill = mode_q;

  // Fill-mode parameter registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      mode_q <= 1'b0;
      fill_q <= 8'd0;
    end else begin
      mode_q <= mode_d;
      fill_q <= fill_d;
    end
  end

  // Latch fill parameters only when a transfer is accepted.
  always_comb begin
    mode_d = mode_q;
    fill_d = fill_q;
    if (state_q == IDLE && Start && !Abort) begin
      mode_d = Mode;
      fill_d = FillData;
    end
  end
`else
  logic unused_fill_inputs;

  assign is_fill            = 1'b0;
  assign unused_fill_inputs = ^{Mode, FillData};
`endif

  // State and transfer bookkeeping registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      src_q   <= 8'd0;
      dst_q   <= 8'd0;
      rem_q   <= 8'd0;
      data_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  // Next-state and counter update; Abort freezes counters and returns to IDLE.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    if (Abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            src_d   = SrcAddr;
            dst_d   = DstAddr;
            rem_d   = Length;
            state_d = (Length == 8'd0) ? DONE : REQ;
          end
        end
        REQ: begin
          if (BusGnt) begin
            state_d = is_fill ? WRITE : READ;
          end
        end
        READ: begin
          if (BusGnt) begin
            state_d = CAPT;
          end
        end
        CAPT: begin
          // RAM output is registered, so the read byte is valid now.
          data_d  = RdData;
          state_d = WRITE;
        end
        WRITE: begin
          if (BusGnt) begin
            dst_d = wrap_inc(dst_q);
            rem_d = rem_q - 8'd1;
            if (!is_fill) begin
              src_d = wrap_inc(src_q);
            end
            if (rem_q == 8'd1) begin
              state_d = DONE;
            end else begin
              state_d = is_fill ? WRITE : READ;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // A RAM access happens only with grant, no abort and reset released.
  assign acc_ok = BusGnt && !Abort && Rst_n;

  // Output decode from registered state, strobes gated by acc_ok.
  always_comb begin
    Busy    = (state_q != IDLE);
    Done    = (state_q == DONE);
    BusReq  = (state_q == REQ) || (state_q == READ) ||
              (state_q == CAPT) || (state_q == WRITE);
    Cs      = acc_ok && ((state_q == READ) || (state_q == WRITE));
    Oen     = acc_ok && (state_q == READ);
    Wen     = acc_ok && (state_q == WRITE);
    Address = 8'd0;
    WrData  = 8'd0;
    if (state_q == READ) begin
      Address = src_q;
    end else if (state_q == WRITE) begin
      Address = dst_q;
`ifdef RAM_DMA_FILL_EN
      WrData  = is_fill ? fill_q : data_q;
`else
      WrData  = data_q;
`endif
    end
  end

  assign Remaining = rem_q;

endmodule
